hertz_tick_gen: RTL and testbench

Timebase and init-control front end for the CMB control LED path. It sits directly upstream of the LED counter, which runs on clk50 and consumes the two outputs as its advance enable and clear level. From clk50 it generates a single-cycle hertz_tick enable at a switch-selectable rate of 1/2/4/8 Hz. It also synchronizes and debounces the raw init push button into the clean sys_init_ctrl level.

---
 rtl/cmb_ctrl_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 60 ++++++
 rtl/hertz_tick_gen.sv | 72 +++++++
 tb/tb_hertz_tick_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cmb_ctrl_pkg.sv
// Shared types and helpers for the CMB control LED front end.
// Holds the rate switch encodings, debounce states and divider sizing.
package cmb_ctrl_pkg;

    typedef enum logic [1:0] {
        RATE_1HZ = 2'b00,
        RATE_2HZ = 2'b01,
        RATE_4HZ = 2'b10,
        RATE_8HZ = 2'b11
    } rate_e;

    typedef enum logic {
        DB_RELEASED = 1'b0,
        DB_PRESSED  = 1'b1
    } db_state_e;

    localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;

    // Width of a counter that must hold 0..clk_hz-1 (the 1 Hz period).
    function automatic int unsigned div_width(input int unsigned clk_hz);
        return $clog2(clk_hz);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus a two-state debounce FSM for one raw button.
// The level flips only after DB_CYCLES consecutive synchronized samples disagree with it.
module btn_debounce
    import cmb_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level
);

    localparam int unsigned CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    db_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            btn_s;
    logic            state_lvl;

    assign btn_s     = sync2_q;
    assign state_lvl = (state_q == DB_PRESSED);

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (btn_s == state_lvl) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Disagreement has lasted the full window: accept the new level.
            state_d = (state_q == DB_PRESSED) ? DB_RELEASED : DB_PRESSED;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= DB_RELEASED;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The state flop itself is the clean output level.
    assign btn_level = (state_q == DB_PRESSED);

endmodule

// File: rtl/hertz_tick_gen.sv
// Switch-selectable 1/2/4/8 Hz tick generator with debounced init hold.
// hertz_tick and sys_init_ctrl feed the LED counter directly on clk50.
module hertz_tick_gen
    import cmb_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int unsigned DEBOUNCE_MS = 10
) (
    input  logic       clk50,
    input  logic       rst_n,
    input  logic       init_btn,
    input  logic [1:0] rate_sel,
    output logic       hertz_tick,
    output logic       sys_init_ctrl
);

    localparam longint DB_CYCLES_L = (longint'(CLK_HZ) * longint'(DEBOUNCE_MS)) / 1000;
    localparam int unsigned DB_CYCLES = 32'(DB_CYCLES_L);
    localparam int unsigned DIV_W = div_width(CLK_HZ);

    rate_e            rate_q, rate_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_q, tick_d;
    rate_e            rate_in;

    // Terminal count for a rate: period CLK_HZ >> rate, counted 0..P-1.
    function automatic logic [DIV_W-1:0] last_cnt(input rate_e r);
        return DIV_W'((CLK_HZ >> r) - 1);
    endfunction

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_init_db (
        .clk       (clk50),
        .rst_n     (rst_n),
        .btn_raw   (init_btn),
        .btn_level (sys_init_ctrl)
    );

    assign rate_in = rate_e'(rate_sel);

    always_comb begin
        rate_d    = rate_in;
        div_cnt_d = div_cnt_q + DIV_W'(1);
        tick_d    = 1'b0;
        if (sys_init_ctrl) begin
            // Init hold wins over a rate change; rate_q still tracks the switches.
            div_cnt_d = '0;
        end else if (rate_in != rate_q) begin
            // Restart the period so a switch change can never shorten a tick.
            div_cnt_d = '0;
        end else if (div_cnt_q == last_cnt(rate_q)) begin
            div_cnt_d = '0;
            tick_d    = 1'b1;
        end
    end

    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            rate_q    <= RATE_1HZ;
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            rate_q    <= rate_d;
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
        end
    end

    assign hertz_tick = tick_q;

endmodule

// File: tb/tb_hertz_tick_gen.sv
// Randomized and directed bench for hertz_tick_gen at CLK_HZ=800, DEBOUNCE_MS=10.
module tb_hertz_tick_gen;

    localparam int unsigned CLK_HZ      = 800;
    localparam int unsigned DEBOUNCE_MS = 10;
    localparam int          DB          = 8;

    logic       clk50 = 1'b0;
    logic       rst_n;
    logic       init_btn;
    logic [1:0] rate_sel;
    logic       hertz_tick;
    logic       sys_init_ctrl;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    bit         m_tick, m_init, d1, d2;
    logic [1:0] m_rate;
    int         m_since;
    bit         win[$];

    // Observation records
    int ticks[$];
    int rise_cyc = -1;
    int fall_cyc = -1;
    bit prev_init = 1'b0;

    always #5 clk50 = ~clk50;

    hertz_tick_gen #(
        .CLK_HZ      (CLK_HZ),
        .DEBOUNCE_MS (DEBOUNCE_MS)
    ) dut (
        .clk50         (clk50),
        .rst_n         (rst_n),
        .init_btn      (init_btn),
        .rate_sel      (rate_sel),
        .hertz_tick    (hertz_tick),
        .sys_init_ctrl (sys_init_ctrl)
    );

    initial forever begin
        @(posedge clk50);
        cyc++;
    end

    // Model: level flips after DB consecutive synchronized samples disagree;
    // a tick comes P edges after the last restart (reset, hold release, rate change).
    task automatic model_step();
        bit bs, old_init, all_diff;
        if (!rst_n) begin
            m_tick = 0; m_init = 0; d1 = 0; d2 = 0;
            m_rate = 2'b00; m_since = 0; win.delete();
            return;
        end
        bs = d2; d2 = d1; d1 = init_btn;
        old_init = m_init;
        win.push_back(bs);
        if (win.size() > DB) void'(win.pop_front());
        all_diff = (win.size() == DB);
        foreach (win[i]) if (win[i] == m_init) all_diff = 0;
        if (all_diff) begin
            m_init = !m_init;
            win.delete();
        end
        m_tick = 0;
        if (old_init) begin
            m_rate = rate_sel; m_since = 0;
        end else if (rate_sel != m_rate) begin
            m_rate = rate_sel; m_since = 0;
        end else begin
            m_since++;
            if (m_since == int'(CLK_HZ >> m_rate)) begin
                m_tick = 1; m_since = 0;
            end
        end
    endtask

    initial forever begin
        @(posedge clk50 or negedge rst_n);
        model_step();
    end

    // Per-cycle compare against the model, plus tick/edge recording.
    initial forever begin
        @(negedge clk50);
        checks++;
        if (hertz_tick !== m_tick) begin
            errors++;
            $display("FAIL tick_model cyc=%0d: got %b, expected %b", cyc, hertz_tick, m_tick);
        end
        checks++;
        if (sys_init_ctrl !== m_init) begin
            errors++;
            $display("FAIL init_model cyc=%0d: got %b, expected %b", cyc, sys_init_ctrl, m_init);
        end
        if (hertz_tick === 1'b1) ticks.push_back(cyc);
        if (sys_init_ctrl === 1'b1 && !prev_init) rise_cyc = cyc;
        if (sys_init_ctrl === 1'b0 && prev_init)  fall_cyc = cyc;
        prev_init = (sys_init_ctrl === 1'b1);
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk50);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int n_ticks(input int lo, input int hi);
        int n = 0;
        foreach (ticks[i]) if (ticks[i] > lo && ticks[i] <= hi) n++;
        return n;
    endfunction

    function automatic int first_tick(input int lo);
        foreach (ticks[i]) if (ticks[i] > lo) return ticks[i];
        return -1;
    endfunction

    task automatic wait_tick(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk50);
            #1;
            if (hertz_tick === 1'b1) begin
                t = cyc;
                break;
            end
        end
        checks++;
        if (t < 0) begin
            errors++;
            $display("FAIL wait_tick: got no tick, expected one within %0d cycles", budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r0, h, f, t, c, s, tk;
        rst_n = 0; init_btn = 0; rate_sel = 2'b11;
        run(4);
        chk("reset_tick", int'(hertz_tick), 0);
        chk("reset_init", int'(sys_init_ctrl), 0);

        // 8 Hz from reset: rate_reg resets to 00, so edge 1 captures 11 and restarts.
        rst_n = 1; r0 = cyc;
        run(320);
        chk("s1_first",  first_tick(r0), r0 + 101);
        chk("s1_second", first_tick(r0 + 101), r0 + 201);
        chk("s1_count",  n_ticks(r0, r0 + 320), 3);

        // Bounce in 3-cycle bursts, then a stable press.
        for (int b = 0; b < 8; b++) begin
            init_btn = (b % 2 == 0);
            run(3);
        end
        chk("s2_no_bounce", rise_cyc, -1);
        init_btn = 1; h = cyc;
        run(150);
        chk("s2_rise", rise_cyc, h + 10);
        chk("s2_hold_ticks", n_ticks(rise_cyc, cyc), 0);
        init_btn = 0; f = cyc;
        run(130);
        chk("s2_fall", fall_cyc, f + 10);
        chk("s2_first_after", first_tick(fall_cyc), f + 110);

        // 11 -> 00 at div_cnt = 50.
        wait_tick(200, t);
        run(50);
        rate_sel = 2'b00; c = cyc;
        run(900);
        chk("s3_no_old", n_ticks(c, c + 800), 0);
        chk("s3_next", first_tick(c), c + 801);

        // Switch glitching every 20 cycles.
        s = cyc;
        for (int k = 0; k < 10; k++) begin
            rate_sel = (k % 2) ? 2'b10 : 2'b11;
            run(20);
        end
        chk("s4_none", n_ticks(s, s + 200), 0);
        run(220);
        chk("s4_after", first_tick(s), s + 180 + 201);

        // Reset while held in init, right after sys_init_ctrl rises.
        init_btn = 1; t = -1;
        for (int i = 0; i < 40; i++) begin
            run(1);
            if (sys_init_ctrl === 1'b1) begin t = cyc; break; end
        end
        chk("s5_pressed", int'(t >= 0), 1);
        rst_n = 0;
        #1;
        chk("s5_rst_tick", int'(hertz_tick), 0);
        chk("s5_rst_init", int'(sys_init_ctrl), 0);
        run(3);
        rise_cyc = -1;
        rst_n = 1; r0 = cyc;
        run(30);
        chk("s5_redebounce", rise_cyc, r0 + 10);
        init_btn = 0;
        run(20);

        // 1 Hz with rate already matching the reset value of the rate register.
        rate_sel = 2'b00; rst_n = 0;
        run(2);
        rst_n = 1; r0 = cyc;
        run(4000);
        chk("s6_count", n_ticks(r0, r0 + 4000), 5);
        tk = r0;
        for (int k = 1; k <= 5; k++) begin
            tk = first_tick(tk);
            chk("s6_tick", tk, r0 + 800 * k);
        end

        // Random button segments and occasional rate changes, model-checked.
        s = cyc;
        while (cyc < s + 3000) begin
            init_btn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) rate_sel = 2'($urandom_range(0, 3));
            run($urandom_range(1, 40));
        end
        init_btn = 0; rate_sel = 2'b11;
        run(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
